// File: rtl/register_alias_table_pkg.sv
// Shared definitions for the register alias table (RAT).
// Holds the table geometry, index/entry types and the CDB-to-read bypass switch.
// Configuration macro: RAT_CDB_BYPASS_EN. When defined, a read port also reports valid
// in the same cycle as a matching CDB broadcast. When undefined, reads see registered
// state only.
package register_alias_table_pkg;

  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam int unsigned NUM_PHYS_REGS = 64;
  localparam int unsigned AREG_W        = $clog2(NUM_ARCH_REGS);
  localparam int unsigned PREG_W        = $clog2(NUM_PHYS_REGS);

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    preg_t pd;
    logic  valid;
  } rat_entry_t;

`ifdef RAT_CDB_BYPASS_EN
  localparam bit CDB_BYPASS_EN = 1'b1;
`else
  localparam bit CDB_BYPASS_EN = 1'b0;
`endif

  // Identity mapping with the value present: the state every entry returns to on reset.
  function automatic rat_entry_t reset_entry(areg_t idx);
    rat_entry_t e;
    e.pd    = preg_t'(idx);
    e.valid = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/register_alias_table_if.sv
// Rename-stage bus of the register alias table.
// Signals:
//   rs1/rs2                 source architectural indices (read request)
//   ps1/ps2, ps1/ps2_valid  physical mapping and value-ready bit per source
//   rd/pd/regf_we_dispatch  new rd->pd mapping installed by dispatch
//   rd/pd/regf_we_cdb       completion broadcast marking a mapping ready
// Modports: master drives requests (rename/dispatch/CDB side), slave is the RAT.
interface register_alias_table_if;
  import register_alias_table_pkg::*;

  areg_t rs1;
  areg_t rs2;
  preg_t ps1;
  preg_t ps2;
  logic  ps1_valid;
  logic  ps2_valid;
  areg_t rd_dispatch;
  preg_t pd_dispatch;
  logic  regf_we_dispatch;
  areg_t rd_cdb;
  preg_t pd_cdb;
  logic  regf_we_cdb;

  modport master (
    output rs1, rs2,
    output rd_dispatch, pd_dispatch, regf_we_dispatch,
    output rd_cdb, pd_cdb, regf_we_cdb,
    input  ps1, ps2, ps1_valid, ps2_valid
  );

  modport slave (
    input  rs1, rs2,
    input  rd_dispatch, pd_dispatch, regf_we_dispatch,
    input  rd_cdb, pd_cdb, regf_we_cdb,
    output ps1, ps2, ps1_valid, ps2_valid
  );

endinterface

// File: rtl/register_alias_table_read_port.sv
// One combinational RAT read port: looks up the entry for a source register and,
// when RAT_CDB_BYPASS_EN is defined, forwards a same-cycle CDB completion as valid.
// Ports:
//   i_table     current registered table contents
//   i_rs        source architectural index
//   i_cdb_we    CDB broadcast valid
//   i_cdb_rd    CDB architectural destination
//   i_cdb_pd    CDB physical destination
//   o_ps        physical mapping of i_rs
//   o_ps_valid  value of o_ps is available (registered, or bypassed from the CDB)
module register_alias_table_read_port
  import register_alias_table_pkg::*;
(
  input  rat_entry_t i_table [NUM_ARCH_REGS],
  input  areg_t      i_rs,
  input  logic       i_cdb_we,
  input  areg_t      i_cdb_rd,
  input  preg_t      i_cdb_pd,
  output preg_t      o_ps,
  output logic       o_ps_valid
);

  rat_entry_t w_entry;
  logic       w_cdb_hit;

  always_comb begin
    w_entry = i_table[i_rs];
    // The pd compare drops broadcasts for a mapping that has since been renamed.
    w_cdb_hit = i_cdb_we && (i_rs != '0) && (i_cdb_rd == i_rs) && (w_entry.pd == i_cdb_pd);
    o_ps       = w_entry.pd;
    o_ps_valid = w_entry.valid | (CDB_BYPASS_EN & w_cdb_hit);
  end

endmodule

// File: rtl/register_alias_table.sv
// Register alias table: maps each architectural register to its current physical
// register plus a value-ready bit. Two combinational read ports serve rename,
// dispatch installs new mappings (marked not ready), and the CDB marks them ready.
// Optional same-cycle CDB-to-read forwarding is enabled by RAT_CDB_BYPASS_EN.
// Ports:
//   clk     clock, all state updates on the rising edge
//   rst     asynchronous active-high reset; restores the identity map, all valid
//   io_bus  rename bus (slave modport of register_alias_table_if)
module register_alias_table
  import register_alias_table_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  register_alias_table_if.slave io_bus
);

  rat_entry_t r_rat      [NUM_ARCH_REGS];
  rat_entry_t w_rat_next [NUM_ARCH_REGS];
  logic       w_disp_en;
  logic       w_cdb_en;

  // x0 is never written, so entry 0 keeps its reset value (p0, valid) forever.
  always_comb begin
    w_disp_en = io_bus.regf_we_dispatch && (io_bus.rd_dispatch != '0);
    w_cdb_en  = io_bus.regf_we_cdb && (io_bus.rd_cdb != '0) &&
                (r_rat[io_bus.rd_cdb].pd == io_bus.pd_cdb);
    w_rat_next = r_rat;
    if (w_cdb_en) begin
      w_rat_next[io_bus.rd_cdb].valid = 1'b1;
    end
    // Applied after the CDB update so a new mapping to the same rd takes priority.
    if (w_disp_en) begin
      w_rat_next[io_bus.rd_dispatch].pd    = io_bus.pd_dispatch;
      w_rat_next[io_bus.rd_dispatch].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        r_rat[i] <= reset_entry(areg_t'(i));
      end
    end else begin
      r_rat <= w_rat_next;
    end
  end

  register_alias_table_read_port u_read_port_1 (
    .i_table    (r_rat),
    .i_rs       (io_bus.rs1),
    .i_cdb_we   (io_bus.regf_we_cdb),
    .i_cdb_rd   (io_bus.rd_cdb),
    .i_cdb_pd   (io_bus.pd_cdb),
    .o_ps       (io_bus.ps1),
    .o_ps_valid (io_bus.ps1_valid)
  );

  register_alias_table_read_port u_read_port_2 (
    .i_table    (r_rat),
    .i_rs       (io_bus.rs2),
    .i_cdb_we   (io_bus.regf_we_cdb),
    .i_cdb_rd   (io_bus.rd_cdb),
    .i_cdb_pd   (io_bus.pd_cdb),
    .o_ps       (io_bus.ps2),
    .o_ps_valid (io_bus.ps2_valid)
  );

endmodule

// File: tb/tb_register_alias_table.sv
// Testbench for register_alias_table: directed rename/CDB scenarios followed by a
// randomised phase against a behavioural model; expected read results are queued
// when stimulus is driven and compared when the read ports are sampled.
module tb_register_alias_table;
  import register_alias_table_pkg::*;

`ifdef RAT_CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_alias_table_if bus ();

  register_alias_table dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct {
    string tag;
    preg_t ps1;
    logic  v1;
    preg_t ps2;
    logic  v2;
  } exp_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  preg_t m_pd [NUM_ARCH_REGS];
  logic  m_v  [NUM_ARCH_REGS];

  task automatic drive(int a, int b, int dwe, int drd, int dpd, int cwe, int crd, int cpd);
    bus.rs1              = areg_t'(a);
    bus.rs2              = areg_t'(b);
    bus.regf_we_dispatch = (dwe != 0);
    bus.rd_dispatch      = areg_t'(drd);
    bus.pd_dispatch      = preg_t'(dpd);
    bus.regf_we_cdb      = (cwe != 0);
    bus.rd_cdb           = areg_t'(crd);
    bus.pd_cdb           = preg_t'(cpd);
  endtask

  task automatic expect_rd(string tag, int p1, int v1, int p2, int v2);
    exp_t e;
    e.tag = tag;
    e.ps1 = preg_t'(p1);
    e.v1  = (v1 != 0);
    e.ps2 = preg_t'(p2);
    e.v2  = (v2 != 0);
    sb.push_back(e);
  endtask

  task automatic check_rd();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_underflow got empty queue required one entry");
      return;
    end
    e = sb.pop_front();
    n_tests++;
    assert (bus.ps1 === e.ps1) else begin
      n_fail++;
      $error("FAIL %s ps1 got %0d expected %0d", e.tag, bus.ps1, e.ps1);
    end
    n_tests++;
    assert (bus.ps1_valid === e.v1) else begin
      n_fail++;
      $error("FAIL %s ps1_valid got %0b expected %0b", e.tag, bus.ps1_valid, e.v1);
    end
    n_tests++;
    assert (bus.ps2 === e.ps2) else begin
      n_fail++;
      $error("FAIL %s ps2 got %0d expected %0d", e.tag, bus.ps2, e.ps2);
    end
    n_tests++;
    assert (bus.ps2_valid === e.v2) else begin
      n_fail++;
      $error("FAIL %s ps2_valid got %0b expected %0b", e.tag, bus.ps2_valid, e.v2);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample reads 1 ns later, well before
  // the rising edge that commits the writes.
  task automatic cyc(string tag, int a, int b, int dwe, int drd, int dpd,
                     int cwe, int crd, int cpd, int e1, int v1, int e2, int v2);
    @(negedge clk);
    drive(a, b, dwe, drd, dpd, cwe, crd, cpd);
    expect_rd(tag, e1, v1, e2, v2);
    #1;
    check_rd();
  endtask

  initial begin
    int a, b, dwe, drd, dpd, cwe, crd, cpd, v1, v2;

    // Reset: identity map readable while reset is still asserted.
    rst = 1'b1;
    drive(1, 2, 0, 0, 0, 0, 0, 0);
    expect_rd("reset_identity", 1, 1, 2, 1);
    #2;
    check_rd();
    @(negedge clk);
    rst = 1'b0;

    cyc("after_reset",       1, 2,  0, 0, 0,   0, 0, 0,   1, 1, 2, 1);
    // Dispatch rd1->p32: not visible until after the edge.
    cyc("disp1_same_cycle",  1, 2,  1, 1, 32,  0, 0, 0,   1, 1, 2, 1);
    cyc("disp1_next",        1, 2,  0, 0, 0,   0, 0, 0,   32, 0, 2, 1);
    // CDB completes p32.
    cyc("cdb1_same_cycle",   1, 15, 0, 0, 0,   1, 1, 32,  32, BYP, 15, 1);
    cyc("cdb1_next",         1, 15, 0, 0, 0,   0, 0, 0,   32, 1, 15, 1);
    // Stale broadcast after rd3 was renamed twice.
    cyc("disp3_40",          3, 0,  1, 3, 40,  0, 0, 0,   3, 1, 0, 1);
    cyc("disp3_41",          3, 0,  1, 3, 41,  0, 0, 0,   40, 0, 0, 1);
    cyc("stale_cdb3",        3, 0,  0, 0, 0,   1, 3, 40,  41, 0, 0, 1);
    cyc("stale_cdb3_next",   3, 0,  0, 0, 0,   0, 0, 0,   41, 0, 0, 1);
    // Dispatch and CDB to the same rd in one cycle: dispatch wins.
    cyc("disp_cdb_rd5",      5, 5,  1, 5, 50,  1, 5, 5,   5, 1, 5, 1);
    cyc("rd5_after_x0_disp", 5, 0,  1, 0, 60,  0, 0, 0,   50, 0, 0, 1);
    cyc("x0_ignored",        0, 5,  0, 0, 0,   0, 0, 0,   0, 1, 50, 0);
    // Dispatch and CDB to different rds apply independently.
    cyc("disp6_cdb3",        3, 6,  1, 6, 52,  1, 3, 41,  41, BYP, 6, 1);
    cyc("disp6_cdb3_next",   3, 6,  0, 0, 0,   0, 0, 0,   41, 1, 52, 0);
    // Bypass scenario on rd7 with both ports on the same source.
    cyc("disp7_45",          7, 0,  1, 7, 45,  0, 0, 0,   7, 1, 0, 1);
    cyc("cdb7_same_cycle",   7, 7,  0, 0, 0,   1, 7, 45,  45, BYP, 45, BYP);
    cyc("cdb7_next",         7, 7,  0, 0, 0,   0, 0, 0,   45, 1, 45, 1);

    // Reset in the middle of operation, with a dispatch pending.
    @(negedge clk);
    drive(3, 6, 1, 3, 9, 0, 0, 0);
    expect_rd("pre_midreset", 41, 1, 52, 0);
    #1;
    check_rd();
    rst = 1'b1;
    expect_rd("midreset_async", 3, 1, 6, 1);
    #1;
    check_rd();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("after_midreset",    3, 6,  0, 0, 0,   0, 0, 0,   3, 1, 6, 1);

    // Randomised phase against a behavioural model starting from identity.
    for (int i = 0; i < NUM_ARCH_REGS; i++) begin
      m_pd[i] = preg_t'(i);
      m_v[i]  = 1'b1;
    end
    for (int n = 0; n < 300; n++) begin
      a   = int'($urandom_range(0, 31));
      b   = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 31));
      dwe = int'($urandom_range(0, 1));
      drd = int'($urandom_range(0, 31));
      dpd = int'($urandom_range(0, 63));
      cwe = ($urandom_range(0, 3) != 0) ? 1 : 0;
      crd = ($urandom_range(0, 1) != 0) ? a : int'($urandom_range(0, 31));
      cpd = ($urandom_range(0, 3) != 0) ? int'(m_pd[crd]) : int'($urandom_range(0, 63));
      v1  = int'(m_v[a] | (BYP & (cwe != 0) & (a != 0) & (crd == a) & (int'(m_pd[a]) == cpd)));
      v2  = int'(m_v[b] | (BYP & (cwe != 0) & (b != 0) & (crd == b) & (int'(m_pd[b]) == cpd)));
      cyc("random", a, b, dwe, drd, dpd, cwe, crd, cpd, int'(m_pd[a]), v1, int'(m_pd[b]), v2);
      if ((cwe != 0) && (crd != 0) && (int'(m_pd[crd]) == cpd)) m_v[crd] = 1'b1;
      if ((dwe != 0) && (drd != 0)) begin
        m_pd[drd] = preg_t'(dpd);
        m_v[drd]  = 1'b0;
      end
    end

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
